trace_stream_arbiter: RTL and testbench
=======================================

TRACE_STREAM_ARBITER -- requirements
Module: trace_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, legal range 2..8: number of trace sources, for example one continuous monitoring system per core.
REQ-002 SHALL have parameter ID_WIDTH, default $clog2(NUM_SRC): width of the source-ID output.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port S_AXIS_tvalid, input, NUM_SRC bits: per-source valid.
REQ-006 SHALL have port S_AXIS_tready, output, NUM_SRC bits: per-source ready.
REQ-007 SHALL have port S_AXIS_tdata, input, NUM_SRC*AXI_DATA_WIDTH bits: source i occupies slice [i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
REQ-008 SHALL have port S_AXIS_tlast, input, NUM_SRC bits: per-source packet end.
REQ-009 SHALL have port src_enable, input, NUM_SRC bits: a source whose bit is 0 is never granted.
REQ-010 SHALL have port max_beats, input, 16 bits: burst cap per grant; 0 means unlimited.
REQ-011 SHALL have port M_AXIS_tvalid, output, 1 bit: merged stream valid.
REQ-012 SHALL have port M_AXIS_tready, input, 1 bit: merged stream ready.
REQ-013 SHALL have port M_AXIS_tdata, output, AXI_DATA_WIDTH bits: merged data.
REQ-014 SHALL have port M_AXIS_tlast, output, 1 bit: marks the last beat of each grant.
REQ-015 SHALL have port M_AXIS_tid, output, ID_WIDTH bits: index of the source that produced the beat.
REQ-016 SHALL have port busy, output, 1 bit: high while in state GRANT.
REQ-017 SHALL have port cur_grant, output, ID_WIDTH bits: index of the currently or last granted source.

Function
REQ-018 SHALL implement FSM states IDLE and GRANT.
REQ-019 In IDLE, each cycle SHALL select the first index with S_AXIS_tvalid & src_enable set, searching round-robin from last_grant+1 modulo NUM_SRC. The result SHALL be registered into cur_grant, and the FSM SHALL enter GRANT on the next edge.
REQ-020 In IDLE, S_AXIS_tready SHALL be all zero.
REQ-021 In GRANT, S_AXIS_tready[cur_grant] SHALL equal buf_ready, and all other ready bits SHALL be 0.
REQ-022 A beat SHALL be accepted when S_AXIS_tvalid[g] & S_AXIS_tready[g] are both high.
REQ-023 beat_cnt, 16 bits, SHALL clear on entering GRANT and increment on each accepted beat.
REQ-024 The grant SHALL release, with the FSM returning to IDLE next cycle, on an accepted beat that satisfies either condition:
- S_AXIS_tlast is high; or
- max_beats != 0 and beat_cnt+1 == max_beats.
REQ-025 The beat that causes release SHALL be forwarded with M_AXIS_tlast = 1. All other beats SHALL have M_AXIS_tlast = 0.
REQ-026 last_grant SHALL update to cur_grant on release.
REQ-027 Exactly one idle bubble cycle SHALL follow every release, and no back-to-back grants are permitted.
REQ-028 If src_enable[cur_grant] falls during GRANT, the current grant SHALL continue until its release condition. Masking affects arbitration only.
REQ-029 A change to max_beats mid-grant SHALL take effect on the next beat compare.
REQ-030 Output path: a 2-entry skid buffer SHALL hold {tid, tlast, tdata}.
- buf_ready = (occupancy < 2), derived from registers only.
- The buffer SHALL sustain 1 beat per cycle while M_AXIS_tready = 1.
REQ-031 Output stability: once M_AXIS_tvalid is high, M_AXIS_tvalid, tdata, tlast and tid SHALL hold stable until M_AXIS_tready is high.
REQ-032 Latency SHALL be 2 cycles from a valid in IDLE to M_AXIS_tvalid, when the buffer is empty and ready is held high:
- tvalid at edge t registers the grant;
- the beat is accepted at edge t+1;
- M_AXIS_tvalid is high after edge t+1.
REQ-033 Data SHALL never be dropped, duplicated or reordered within a source.

Reset
REQ-034 On rst_n low, asynchronously, the block SHALL set:
- state = IDLE;
- last_grant = NUM_SRC-1, so that source 0 wins first;
- cur_grant = 0;
- beat_cnt = 0;
- buffer empty.
REQ-035 Reset values SHALL be: M_AXIS_tvalid = 0, M_AXIS_tdata = 0, M_AXIS_tlast = 0, M_AXIS_tid = 0, S_AXIS_tready = 0, busy = 0.
REQ-036 A reset asserted mid-grant SHALL discard buffered beats, and a partial packet is not completed.

Structure
REQ-037 AXI_DATA_WIDTH SHALL come from continuous_monitoring_system_pkg.
REQ-038 The following SHALL be added to that package:
- typedef enum arb_state_t {ARB_IDLE, ARB_GRANT};
- constant ARB_MAX_SOURCES = 8;
- constant ARB_BEAT_CNT_WIDTH = 16.
REQ-039 The skid buffer SHALL be a sub-module named axis_skid_buffer, parameterised by payload width.
REQ-040 Round-robin selection SHALL be combinational inside trace_stream_arbiter.

Verification
REQ-041 Reset/first grant: NUM_SRC=2, both sources valid from reset release, tlast on beat 1, M ready=1.
- Required: tid sequence 0,1,0,1.
- Required: M_AXIS_tlast on every beat.
- Required: a bubble cycle between beats.
REQ-042 Packet integrity: source 0 sends a 5-beat packet (data 0x10..0x14, tlast on 0x14) while source 1 is valid.
- Required: all 5 beats are output with tid=0 before any tid=1 beat.
- Required: tlast appears only on 0x14.
REQ-043 Burst cap: max_beats=3, source 1 alone sends 7 beats without tlast.
- Required: grants of 3, 3 and 1+ beats.
- Required: M_AXIS_tlast on beats 3 and 6.
- Required: the data sequence is unbroken.
REQ-044 Backpressure: M_AXIS_tready is held low for 10 cycles mid-packet.
- Required: at most 2 beats are accepted from the source.
- Required: outputs are stable.
- Required: no beat is lost or duplicated after ready returns.
REQ-045 Masking: src_enable=2'b10 with both sources valid.
- Required: only tid=1 beats appear.
- Required: clearing src_enable[1] mid-packet still completes that packet.
REQ-046 Async reset: rst_n is pulsed low mid-grant for half a cycle.
- Required: outputs are 0 immediately.
- Required: the next grant goes to source 0.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// continuous_monitoring_system_pkg: shared widths and types for the monitoring system, including the trace arbiter
package continuous_monitoring_system_pkg;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int ARB_MAX_SOURCES = 8;
  localparam int ARB_BEAT_CNT_WIDTH = 16;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/trace_stream_arbiter_if.sv
// trace_stream_arbiter_if: per-source AXI-Stream inputs, merged output stream and arbiter status
interface trace_stream_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int ID_WIDTH = $clog2(NUM_SRC)
);
  import continuous_monitoring_system_pkg::*;
  logic [NUM_SRC-1:0] S_AXIS_tvalid;
  logic [NUM_SRC-1:0] S_AXIS_tready;
  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] S_AXIS_tdata;
  logic [NUM_SRC-1:0] S_AXIS_tlast;
  logic [NUM_SRC-1:0] src_enable;
  logic [ARB_BEAT_CNT_WIDTH-1:0] max_beats;
  logic M_AXIS_tvalid;
  logic M_AXIS_tready;
  logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata;
  logic M_AXIS_tlast;
  logic [ID_WIDTH-1:0] M_AXIS_tid;
  logic busy;
  logic [ID_WIDTH-1:0] cur_grant;
  modport slave (
    input S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, src_enable, max_beats, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast, M_AXIS_tid, busy, cur_grant
  );
  modport master (
    output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, src_enable, max_beats, M_AXIS_tready,
    input S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast, M_AXIS_tid, busy, cur_grant
  );
endinterface

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry FIFO whose input ready depends only on registered occupancy
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] mem [2];
  logic rd, wr;
  logic [1:0] cnt;
  logic push, pop;
  assign in_ready = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data = mem[rd];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  // storage and pointers; head entry stays put until popped, keeping output stable under backpressure
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) mem[wr] <= in_data;
      wr <= push ? ~wr : wr;
      rd <= pop ? ~rd : rd;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/trace_stream_arbiter.sv
// trace_stream_arbiter: round-robin merge of per-source trace streams into one tagged stream
module trace_stream_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
  input logic clk,
  input logic rst_n,
  trace_stream_arbiter_if.slave bus
);
  import continuous_monitoring_system_pkg::*;
  localparam logic [0:0] IDLE = ARB_IDLE;
  localparam logic [0:0] GRANT = ARB_GRANT;
  localparam int PW = ID_WIDTH + 1 + AXI_DATA_WIDTH;
  logic [0:0] state;
  logic [ID_WIDTH-1:0] cur_grant, last_grant, next_grant;
  logic [ARB_BEAT_CNT_WIDTH-1:0] beat_cnt;
  logic [NUM_SRC-1:0] cand;
  logic found, buf_ready, in_valid, accept, beat_last, rel;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic [PW-1:0] out_data;
  assign cand = bus.S_AXIS_tvalid & bus.src_enable;
  // round-robin pick: walk offsets downward so the nearest candidate after last_grant wins
  always_comb begin
    next_grant = '0;
    found = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--)
      if (cand[ID_WIDTH'((int'(last_grant) + k) % NUM_SRC)]) begin
        next_grant = ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
        found = 1'b1;
      end
  end
  assign in_valid = state == GRANT && bus.S_AXIS_tvalid[cur_grant];
  assign accept = in_valid && buf_ready;
  assign beat_last = bus.S_AXIS_tlast[cur_grant] ||
                     (bus.max_beats != '0 && beat_cnt + ARB_BEAT_CNT_WIDTH'(1) == bus.max_beats);
  assign rel = accept && beat_last;
  assign sel_data = bus.S_AXIS_tdata[int'(cur_grant)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign bus.S_AXIS_tready = (state == GRANT && buf_ready) ? NUM_SRC'(1) << cur_grant : '0;
  assign bus.busy = state == GRANT;
  assign bus.cur_grant = cur_grant;
  assign {bus.M_AXIS_tid, bus.M_AXIS_tlast, bus.M_AXIS_tdata} = out_data;
  // grant FSM: arbitrate in IDLE, hold the source until tlast or the burst cap, then one idle bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= ID_WIDTH'(NUM_SRC - 1);
      cur_grant <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= GRANT;
        cur_grant <= next_grant;
        beat_cnt <= '0;
      end
    end else if (accept) begin
      beat_cnt <= beat_cnt + ARB_BEAT_CNT_WIDTH'(1);
      if (rel) begin
        state <= IDLE;
        last_grant <= cur_grant;
      end
    end
  axis_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(buf_ready),
    .in_data({cur_grant, beat_last, sel_data}),
    .out_valid(bus.M_AXIS_tvalid),
    .out_ready(bus.M_AXIS_tready),
    .out_data(out_data)
  );
endmodule

// File: tb/tb_trace_stream_arbiter.sv
// tb_trace_stream_arbiter: directed scenarios with a scoreboard of expected merged beats
module tb_trace_stream_arbiter;
  import continuous_monitoring_system_pkg::*;
  localparam int NS = 2;
  localparam int IW = 1;
  localparam int DW = AXI_DATA_WIDTH;
  typedef logic [IW+DW:0] exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  trace_stream_arbiter_if #(.NUM_SRC(NS), .ID_WIDTH(IW)) bus();
  trace_stream_arbiter #(.NUM_SRC(NS), .ID_WIDTH(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW:0] sq0[$];
  logic [DW:0] sq1[$];
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [NS-1:0] acc;
  logic s_mvalid, s_mready, s_busy;
  logic [NS-1:0] s_sready;
  exp_t s_out;
  bit gap_chk = 1'b0;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic src(int s, logic last, logic [DW-1:0] d);
    if (s == 0) sq0.push_back({last, d});
    else sq1.push_back({last, d});
  endtask

  task automatic expect_beat(int tid, logic last, logic [DW-1:0] d);
    exp_q.push_back({IW'(tid), last, d});
  endtask

  task automatic drive();
    bus.S_AXIS_tvalid = {sq1.size() != 0, sq0.size() != 0};
    {bus.S_AXIS_tlast[0], bus.S_AXIS_tdata[DW-1:0]} = sq0.size() != 0 ? sq0[0] : '0;
    {bus.S_AXIS_tlast[1], bus.S_AXIS_tdata[2*DW-1:DW]} = sq1.size() != 0 ? sq1[0] : '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    acc = bus.S_AXIS_tvalid & bus.S_AXIS_tready;
    s_mvalid = bus.M_AXIS_tvalid;
    s_mready = bus.M_AXIS_tready;
    s_busy = bus.busy;
    s_sready = bus.S_AXIS_tready;
    s_out = {bus.M_AXIS_tid, bus.M_AXIS_tlast, bus.M_AXIS_tdata};
    @(posedge clk);
    #1;
    if (acc[0]) void'(sq0.pop_front());
    if (acc[1]) void'(sq1.pop_front());
    drive();
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 0);
    repeat (3) cycle();
  endtask

  task automatic wait_out(string name);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(s_mvalid && s_mready) && n < 50);
    check({name, "_out_seen"}, 64'(s_mvalid && s_mready), 1);
  endtask

  // scoreboard monitor: every transferred output beat must match the next expected one
  initial begin
    int cyc, last_cyc, nbeat;
    exp_t got, want;
    cyc = 0;
    last_cyc = 0;
    nbeat = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && bus.M_AXIS_tvalid && bus.M_AXIS_tready) begin
        got = {bus.M_AXIS_tid, bus.M_AXIS_tlast, bus.M_AXIS_tdata};
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected none", got);
        end else begin
          want = exp_q.pop_front();
          check("beat", 64'(got), 64'(want));
        end
        if (gap_chk && nbeat > 0) check("beat_gap", 64'(cyc - last_cyc), 2);
        nbeat++;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    int n;
    exp_t ref_out;
    bus.M_AXIS_tready = 1'b1;
    bus.src_enable = 2'b11;
    bus.max_beats = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mvalid", 64'(bus.M_AXIS_tvalid), 0);
    check("rst_tdata", 64'(bus.M_AXIS_tdata), 0);
    check("rst_tlast", 64'(bus.M_AXIS_tlast), 0);
    check("rst_tid", 64'(bus.M_AXIS_tid), 0);
    check("rst_sready", 64'(bus.S_AXIS_tready), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_cur_grant", 64'(bus.cur_grant), 0);
    src(0, 1, 'hA0); src(0, 1, 'hA1); src(1, 1, 'hB0); src(1, 1, 'hB1);
    expect_beat(0, 1, 'hA0); expect_beat(1, 1, 'hB0); expect_beat(0, 1, 'hA1); expect_beat(1, 1, 'hB1);
    drive();
    gap_chk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("lat_busy", 64'(s_busy), 1);
    check("lat_mvalid_early", 64'(s_mvalid), 0);
    cycle();
    check("lat_mvalid", 64'(s_mvalid), 1);
    check("bubble_busy", 64'(s_busy), 0);
    check("bubble_sready", 64'(s_sready), 0);
    wait_drain("first_grant");
    gap_chk = 1'b0;
    for (int i = 0; i < 5; i++) src(0, i == 4, DW'('h10 + i));
    src(1, 0, 'h20); src(1, 1, 'h21);
    for (int i = 0; i < 5; i++) expect_beat(0, i == 4, DW'('h10 + i));
    expect_beat(1, 0, 'h20); expect_beat(1, 1, 'h21);
    drive();
    wait_drain("packet");
    bus.max_beats = 16'd3;
    for (int i = 0; i < 7; i++) src(1, 0, DW'('h30 + i));
    src(1, 1, 'h37);
    for (int i = 0; i < 8; i++) expect_beat(1, i == 2 || i == 5 || i == 7, DW'('h30 + i));
    drive();
    wait_drain("burst_cap");
    bus.max_beats = '0;
    for (int i = 0; i < 6; i++) src(0, i == 5, DW'('h40 + i));
    for (int i = 0; i < 6; i++) expect_beat(0, i == 5, DW'('h40 + i));
    drive();
    wait_out("bp");
    bus.M_AXIS_tready = 1'b0;
    n = 0;
    ref_out = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n += int'(acc[0]);
      check("bp_mvalid", 64'(s_mvalid), 1);
      if (i == 0) ref_out = s_out;
      else check("bp_stable", 64'(s_out), 64'(ref_out));
    end
    check("bp_accepts_le2", 64'(n <= 2), 1);
    bus.M_AXIS_tready = 1'b1;
    wait_drain("backpressure");
    bus.src_enable = 2'b10;
    src(0, 0, 'h50); src(0, 1, 'h51);
    for (int i = 0; i < 4; i++) src(1, i == 3, DW'('h60 + i));
    for (int i = 0; i < 4; i++) expect_beat(1, i == 3, DW'('h60 + i));
    drive();
    wait_out("mask");
    bus.src_enable = 2'b00;
    wait_drain("mask_complete");
    repeat (4) begin
      cycle();
      check("mask_idle", 64'(s_busy || s_mvalid), 0);
    end
    expect_beat(0, 0, 'h50); expect_beat(0, 1, 'h51);
    bus.src_enable = 2'b11;
    wait_drain("mask_reenable");
    for (int i = 0; i < 4; i++) src(1, i == 3, DW'('h80 + i));
    src(0, 1, 'h70);
    for (int i = 0; i < 4; i++) expect_beat(1, i == 3, DW'('h80 + i));
    drive();
    wait_out("arst");
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_mvalid", 64'(bus.M_AXIS_tvalid), 0);
    check("arst_tdata", 64'(bus.M_AXIS_tdata), 0);
    check("arst_tlast", 64'(bus.M_AXIS_tlast), 0);
    check("arst_tid", 64'(bus.M_AXIS_tid), 0);
    check("arst_sready", 64'(bus.S_AXIS_tready), 0);
    check("arst_busy", 64'(bus.busy), 0);
    check("arst_cur_grant", 64'(bus.cur_grant), 0);
    sq0.delete();
    sq1.delete();
    exp_q.delete();
    drive();
    #4;
    rst_n = 1'b1;
    src(0, 1, 'h90); src(1, 1, 'h91);
    expect_beat(0, 1, 'h90); expect_beat(1, 1, 'h91);
    drive();
    wait_drain("after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
